// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core pipeline control logic.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// EX-stage operand forwarding select for one ALU source register.
module forward_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  // The M-stage result is younger than the W-stage result, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/forward control for the
// 5-stage core, data-memory wait tracking and performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards resolved combinationally each cycle
// MEM_WAIT | data memory busy; pipeline frozen until MemReadyM
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            Rs1E,
  input  logic [4:0]            Rs2E,
  input  logic [4:0]            RdE,
  input  logic [6:0]            opcodeE,
  input  logic                  PCSrcE,
  input  logic [4:0]            RdM,
  input  logic                  RegWriteM,
  input  logic [4:0]            RdW,
  input  logic                  RegWriteW,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic                  enF,
  output logic                  enD,
  output logic                  enE,
  output logic                  enM,
  output logic                  enW,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [DATA_WIDTH-1:0] stall_cycles,
  output logic [DATA_WIDTH-1:0] flush_count,
  output logic                  mem_timeout
);

  localparam logic [0:0] S_RUN      = RUN;
  localparam logic [0:0] S_MEM_WAIT = MEM_WAIT;

  localparam int            WW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  logic [0:0]    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          memwait, lduse, br_flush;
  fwd_sel_t      fwd_a, fwd_b;

  forward_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;

  assign memwait = MemAccessM && !MemReadyM;
  assign lduse   = (opcodeE == OP_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // A frozen register must never see a flush: rst overrides en in the
  // pipeline registers. A branch taken during a freeze is simply held in
  // E and acted on in the release cycle.
  always_comb begin
    enF      = 1'b1;
    enD      = 1'b1;
    enE      = 1'b1;
    enM      = 1'b1;
    enW      = 1'b1;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    br_flush = 1'b0;
    if (!rst) begin
      if (memwait) begin
        enF = 1'b0;
        enD = 1'b0;
        enE = 1'b0;
        enM = 1'b0;
        enW = 1'b0;
      end else if (PCSrcE) begin
        FlushD   = 1'b1;
        FlushE   = 1'b1;
        br_flush = 1'b1;
      end else if (lduse) begin
        enF    = 1'b0;
        enD    = 1'b0;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_RUN: begin
        if (memwait) begin
          state_nxt = S_MEM_WAIT;
          wait_nxt  = WAIT_ONE;
        end
      end
      S_MEM_WAIT: begin
        if (MemReadyM) begin
          state_nxt = S_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt < WAIT_MAX) begin
          wait_nxt = wait_cnt + WAIT_ONE;
        end
      end
      default: begin
        state_nxt = S_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!enF) begin
        stall_cycles <= stall_cycles + DATA_WIDTH'(1);
      end
      if (br_flush) begin
        flush_count <= flush_count + DATA_WIDTH'(1);
      end
      // Sticky: the core keeps waiting, software reads the flag later.
      if (wait_nxt == WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the enable and flush (`rst`) inputs of the F/D/E/M/W pipeline registers and the EX-stage forwarding selects. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits through a small FSM, and keeps performance and error counters.

## Interface
Parameters:
- `DATA_WIDTH`, 32: counter width.
- `TIMEOUT_CYCLES`, 256: memory-wait cycles before the timeout flag sets; must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Rs1D`, `Rs2D` in 5 each: source registers in Decode.
- `Rs1E`, `Rs2E`, `RdE` in 5 each: source and destination registers in Execute.
- `opcodeE` in 7: opcode in Execute.
- `PCSrcE` in 1: branch/jump taken in Execute.
- `RdM` in 5, `RegWriteM` in 1: Memory-stage destination and its write enable.
- `RdW` in 5, `RegWriteW` in 1: Writeback-stage destination and its write enable.
- `MemAccessM` in 1: load or store active in the Memory stage.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `enF`, `enD`, `enE`, `enM`, `enW` out 1 each: pipeline register / PC enables.
- `FlushD`, `FlushE` out 1 each: drive the `rst` input of the D and E pipeline registers.
- `ForwardAE`, `ForwardBE` out 2 each: ALU operand select (00 register file, 01 W result, 10 M ALU result).
- `stall_cycles` out `DATA_WIDTH`: count of cycles with `enF`=0.
- `flush_count` out `DATA_WIDTH`: count of taken-branch flushes.
- `mem_timeout` out 1: sticky flag, memory wait ≥ `TIMEOUT_CYCLES`.

## Operation
- **Forwarding** is combinational and independent of the FSM.
  - `ForwardAE` = 10 if `RegWriteM` && `RdM`≠0 && `RdM`==`Rs1E`.
  - Otherwise `ForwardAE` = 01 if `RegWriteW` && `RdW`≠0 && `RdW`==`Rs1E`.
  - Otherwise `ForwardAE` = 00. `ForwardBE` follows the same rules with `Rs2E`.
- **Hazard conditions:**
  - `memwait` = `MemAccessM` && !`MemReadyM`.
  - `lduse` = `opcodeE`==`OP_LOAD` && `RdE`≠0 && (`RdE`==`Rs1D` || `RdE`==`Rs2D`).
- **Priority:** `memwait` > `PCSrcE` > `lduse`.
  - `memwait`: all `en*`=0, both flushes 0. Frozen registers must never be flushed, because `rst` overrides `en` in the pipeline registers.
  - `PCSrcE`: all `en*`=1, `FlushD`=`FlushE`=1. `flush_count` increments.
  - `lduse`: `enF`=`enD`=0, `enE`/`enM`/`enW`=1, `FlushE`=1, `FlushD`=0.
  - No hazard: all `en*`=1, no flush.
- **FSM states:** RUN and MEM_WAIT.
  - RUN → MEM_WAIT when `memwait`; `wait_cnt` loads 1.
  - MEM_WAIT → RUN on `MemReadyM`. Otherwise it stays and `wait_cnt` increments, saturating at `TIMEOUT_CYCLES`.
  - `mem_timeout` sets when `wait_cnt` reaches `TIMEOUT_CYCLES` and clears only on `rst`. The core keeps waiting after timeout.
- **Counters:**
  - `stall_cycles` increments on every non-reset cycle with `enF`=0.
  - Both counters wrap modulo 2^`DATA_WIDTH`.

## Timing
- Enables, flushes and forwards are Mealy outputs: they are valid in the same cycle as the causing inputs, with zero latency.
- A `MemReadyM`=1 cycle in MEM_WAIT has `memwait`=0, so enables release in that same cycle. The state returns to RUN at the next edge.
- If `PCSrcE` is high during a freeze, it stays pending (the E register is frozen). It is acted on in the release cycle with a single flush, and `flush_count` increments once.
- `lduse` stalls exactly one cycle: after the E bubble, `opcodeE` no longer holds the load.
- **Reset** (while `rst`=1 and after):
  - State RUN, `wait_cnt`=0, counters 0, `mem_timeout`=0.
  - Outputs while `rst`=1: `en*`=1, flushes 0, forwards 00.
  - Asserting `rst` mid-MEM_WAIT aborts the wait on the next edge.

## Structure
- `riscv_pkg` holds:
  - `OP_LOAD` = 7'b0000011.
  - `fwd_sel_t` enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - `hz_state_t` enum: RUN, MEM_WAIT.
- Sub-module `forward_sel` holds the combinational forwarding for one operand and is instantiated twice (A and B).
- FSM, counters and priority logic are in `hazard_ctrl`.

## Test plan
- **Forwarding:** `RdM`=5, `RegWriteM`=1, `RdW`=5, `RegWriteW`=1, `Rs1E`=5, `Rs2E`=0 → `ForwardAE`=10, `ForwardBE`=00. Repeat with `RdM`=0 → `ForwardAE`=01.
- **Load-use:** `opcodeE`=0000011, `RdE`=7, `Rs2D`=7 → for one cycle `enF`=`enD`=0, `FlushE`=1, `stall_cycles` +1. Next cycle (`opcodeE`=0) → all enables 1.
- **Branch:** `PCSrcE`=1 coinciding with `lduse` → `FlushD`=`FlushE`=1, `enF`=1, `flush_count` +1, `stall_cycles` unchanged.
- **Memory wait:** `MemAccessM`=1, `MemReadyM` low for 3 cycles then high → all `en*`=0 for 3 cycles, `stall_cycles`=3, back in RUN after the ready edge. `PCSrcE`=1 held throughout → single flush in the release cycle, never during the freeze.
- **Timeout and reset:** with `TIMEOUT_CYCLES`=4, `MemReadyM` low for 6 cycles → `mem_timeout`=1 from the edge after the 4th wait cycle and it stays 1. `rst` pulse mid-wait → state RUN, counters 0, `mem_timeout`=0.
